rls_shift_seq: RTL

Command sequencer that drives an RLS803-compatible 8-bit shift register as its initiator. It accepts shift requests of 0–15 positions over a valid/ready handshake and loads the operand into the shifter. It then issues as many ≤7-position shift steps as needed, captures the shifter output, and checks it against an internal reference model. The result returns on a valid/ready response channel. It sits between the datapath controller and the RLS803 instance.

---
 rtl/rls_pkg.sv | 28 ++
 rtl/rls_shift_model.sv | 18 +
 rtl/rls_shift_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rls_pkg.sv
// Shared types and constants for the RLS803 shift sequencer and its reference model.
package rls_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned AMT_W    = 4;
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MAX_STEP = 7;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STEP    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Latched request payload.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amount;
        logic              dir;
    } req_t;

endpackage

// File: rtl/rls_shift_model.sv
// Combinational 8-bit logical shift by 0-15 positions; shifts of 8 or more yield zero.
module rls_shift_model
    import rls_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amount_i,
    input  logic              dir_i,
    output logic [DATA_W-1:0] result_c
);

    always_comb begin
        result_c = '0;
        if (amount_i < AMT_W'(DATA_W)) begin
            result_c = (dir_i == DIR_LEFT) ? (data_i << amount_i) : (data_i >> amount_i);
        end
    end

endmodule

// File: rtl/rls_shift_seq.sv
// Sequencer driving an RLS803 shifter: load, chunked shift steps, capture and self-check,
// with valid/ready request and response channels.
module rls_shift_seq
    import rls_pkg::*;
#(
    parameter int unsigned MAX_STEP = rls_pkg::MAX_STEP
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [AMT_W-1:0]    req_amount,
    input  logic                req_dir,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic [CNT_W-1:0]    err_count,
    output logic [DATA_W-1:0]   sh_data_in,
    output logic [STEP_W-1:0]   sh_shift_amount,
    output logic                sh_direction,
    output logic                sh_clear_n,
    input  logic [DATA_W-1:0]   sh_data_out
);

    state_e              state_q, state_d;
    req_t                op_q, op_d;
    logic [AMT_W-1:0]    rem_q, rem_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   chunk;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                sh_clear_n_q, sh_clear_n_d;
    logic [DATA_W-1:0]   expected;

    rls_shift_model u_model (
        .data_i   (op_q.data),
        .amount_i (op_q.amount),
        .dir_i    (op_q.dir),
        .result_c (expected)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            rem_q        <= '0;
            step_q       <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            err_count_q  <= '0;
            sh_clear_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rem_q        <= rem_d;
            step_q       <= step_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            err_count_q  <= err_count_d;
            sh_clear_n_q <= sh_clear_n_d;
        end
    end

    // Next state plus next registered outputs, decoded from the state being entered.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rem_d        = rem_q;
        step_d       = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        err_count_d  = err_count_q;
        chunk        = (rem_q > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(rem_q);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = '{data: req_data, amount: req_amount, dir: req_dir};
                    rem_d   = req_amount;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD, ST_STEP: begin
                if (rem_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_STEP;
                    step_d  = chunk;
                    rem_d   = rem_q - AMT_W'(chunk);
                end
            end
            ST_CAPTURE: begin
                rsp_data_d = sh_data_out;
                rsp_err_d  = (sh_data_out != expected);
                if (rsp_err_d && (err_count_q != '1)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        rsp_valid_d  = (state_d == ST_RESP);
        sh_clear_n_d = (state_d == ST_LOAD) || (state_d == ST_STEP) || (state_d == ST_CAPTURE);
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign err_count       = err_count_q;
    assign sh_data_in      = op_q.data;
    assign sh_shift_amount = step_q;
    assign sh_direction    = op_q.dir;
    assign sh_clear_n      = sh_clear_n_q;

endmodule
